// File: rtl/two_port_rr_arbiter.sv
// rtl/two_port_rr_arbiter.sv - two-requester round-robin arbiter with burst limit
//
// Ports:
//   clk            single clock, all state changes on posedge
//   reset          asynchronous active-high reset
//   req_a, req_b   requester A / B wants the shared channel
//   a, b           requester A / B data (WIDTH bits)
//   grant_a        registered, A owns the channel
//   grant_b        registered, B owns the channel
//   x_var          shared channel data (a in GNT_A, b in GNT_B, zero in IDLE)
//   valid          grant_a | grant_b
//   lock           (only with ARB_LOCK_EN) suppresses the burst limit for the owner
//
// Build option: define ARB_LOCK_EN to add the lock input.
module two_port_rr_arbiter #(
    parameter int WIDTH     = 2,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic             req_b,
`ifdef ARB_LOCK_EN
    input  logic             lock,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             grant_a,
    output logic             grant_b,
    output logic [WIDTH-1:0] x_var,
    output logic             valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_A = 2'b01,
        GNT_B = 2'b10
    } state_t;

    localparam logic [3:0] CNT_MAX = 4'(MAX_BURST - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_a_q, last_a_d;
    logic       grant_a_q, grant_b_q;
    logic       lock_w;
    logic       win_a;

`ifdef ARB_LOCK_EN
    assign lock_w = lock;
`else
    assign lock_w = 1'b0;
`endif

    // Fresh arbitration: A wins if it is the only requester, or both request
    // and the pointer says B was served last.
    assign win_a = req_a && (!req_b || !last_a_q);

    always_comb begin
        state_d  = IDLE;
        cnt_d    = '0;
        last_a_d = last_a_q;

        case (state_q)
            IDLE: begin
                if (req_a || req_b)
                    state_d = win_a ? GNT_A : GNT_B;
            end
            GNT_A: begin
                if (req_a)
                    state_d = (req_b && cnt_q == CNT_MAX && !lock_w) ? GNT_B : GNT_A;
                else
                    state_d = req_b ? GNT_B : IDLE;
            end
            GNT_B: begin
                if (req_b)
                    state_d = (req_a && cnt_q == CNT_MAX && !lock_w) ? GNT_A : GNT_B;
                else
                    state_d = req_a ? GNT_A : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Counter runs only while the same owner keeps the channel; any
        // change of grant (including entry from IDLE) restarts it at zero.
        if (state_d != IDLE && state_d == state_q)
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;

        if (state_d == GNT_A && state_q != GNT_A)
            last_a_d = 1'b1;
        else if (state_d == GNT_B && state_q != GNT_B)
            last_a_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_a_q  <= 1'b0;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_a_q  <= last_a_d;
            grant_a_q <= (state_d == GNT_A);
            grant_b_q <= (state_d == GNT_B);
        end
    end

    always_comb begin
        x_var = '0;
        case (state_q)
            GNT_A:   x_var = a;
            GNT_B:   x_var = b;
            default: x_var = '0;
        endcase
    end

    assign grant_a = grant_a_q;
    assign grant_b = grant_b_q;
    assign valid   = grant_a_q | grant_b_q;

endmodule

// File: tb/tb_two_port_rr_arbiter.sv
// tb/tb_two_port_rr_arbiter.sv - scoreboard bench for two_port_rr_arbiter
module tb_two_port_rr_arbiter;

    localparam int W = 2;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic         req_a  = 1'b0;
    logic         req_b  = 1'b0;
    logic         lock   = 1'b0;
    logic [W-1:0] a      = '0;
    logic [W-1:0] b      = '0;
    logic         grant_a, grant_b, valid;
    logic [W-1:0] x_var;

    typedef struct {
        logic         ga;
        logic         gb;
        logic [W-1:0] x;
        string        tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    event async_ev;

    two_port_rr_arbiter #(.WIDTH(W), .MAX_BURST(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req_a   (req_a),
        .req_b   (req_b),
`ifdef ARB_LOCK_EN
        .lock    (lock),
`endif
        .a       (a),
        .b       (b),
        .grant_a (grant_a),
        .grant_b (grant_b),
        .x_var   (x_var),
        .valid   (valid)
    );

    always #5 clk = ~clk;

    task automatic check_one();
        exp_t e;
        if (exp_q.size() == 0)
            return;
        e = exp_q.pop_front();
        total++;
        if (grant_a !== e.ga || grant_b !== e.gb || x_var !== e.x || valid !== (e.ga | e.gb)) begin
            bad++;
            $display("FAIL %s: got ga=%b gb=%b x=%b valid=%b, want ga=%b gb=%b x=%b valid=%b",
                     e.tag, grant_a, grant_b, x_var, valid, e.ga, e.gb, e.x, e.ga | e.gb);
        end
    endtask

    always @(posedge clk) begin
        #1;
        check_one();
    end

    always @(async_ev) begin
        #1;
        check_one();
    end

    task automatic push_exp(input logic ega, input logic egb, input logic [W-1:0] ex, input string tag);
        exp_t e;
        e.ga  = ega;
        e.gb  = egb;
        e.x   = ex;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Drive inputs at negedge, record what the outputs must be after the next posedge.
    task automatic step(input logic ra, input logic rb, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ega, input logic egb, input logic [W-1:0] ex, input string tag);
        @(negedge clk);
        req_a = ra;
        req_b = rb;
        a     = av;
        b     = bv;
        push_exp(ega, egb, ex, tag);
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with both requesting: nothing granted.
        reset = 1'b1;
        step(1, 1, 2'b01, 2'b10, 0, 0, 2'b00, "rst_hold");
        #2 reset = 1'b0;
        step(1, 1, 2'b01, 2'b10, 1, 0, 2'b01, "first_grant_a");

        // Contention: 4 cycles A, 4 cycles B, 4 cycles A.
        for (int i = 0; i < 3; i++) step(1, 1, 2'b01, 2'b10, 1, 0, 2'b01, "burst_a");
        for (int i = 0; i < 4; i++) step(1, 1, 2'b01, 2'b10, 0, 1, 2'b10, "burst_b");
        for (int i = 0; i < 4; i++) step(1, 1, 2'b01, 2'b10, 1, 0, 2'b01, "burst_a2");

        // Only B for 10 cycles: held, no switch; then IDLE.
        for (int i = 0; i < 10; i++) step(0, 1, 2'b01, 2'b10, 0, 1, 2'b10, "only_b");
        step(0, 0, 2'b01, 2'b10, 0, 0, 2'b00, "idle_after_b");

        // A owner drops at its 2nd cycle while B waits: direct handover, counter restarts.
        step(1, 0, 2'b11, 2'b10, 1, 0, 2'b11, "a_alone");
        step(1, 1, 2'b11, 2'b10, 1, 0, 2'b11, "a_cycle2");
        step(0, 1, 2'b11, 2'b10, 0, 1, 2'b10, "handover_b");
        for (int i = 0; i < 3; i++) step(1, 1, 2'b11, 2'b10, 0, 1, 2'b10, "b_restart");
        step(1, 1, 2'b11, 2'b10, 1, 0, 2'b11, "back_to_a");

        // Async reset in the middle of a B burst.
        step(0, 1, 2'b01, 2'b10, 0, 1, 2'b10, "b_burst");
        step(0, 1, 2'b01, 2'b10, 0, 1, 2'b10, "b_burst2");
        @(negedge clk);
        #2;
        reset = 1'b1;
        req_a = 1'b1;
        req_b = 1'b1;
        push_exp(0, 0, 2'b00, "async_rst");
        ->async_ev;
        step(1, 1, 2'b01, 2'b10, 0, 0, 2'b00, "rst_held2");
        #2 reset = 1'b0;
        step(1, 1, 2'b01, 2'b10, 1, 0, 2'b01, "post_rst_a");

        // Sole owner tracks data changes combinationally; then release.
        step(1, 0, 2'b11, 2'b00, 1, 0, 2'b11, "a_data");
        step(1, 0, 2'b10, 2'b00, 1, 0, 2'b10, "a_data_change");
        step(0, 0, 2'b10, 2'b00, 0, 0, 2'b00, "final_idle");

`ifdef ARB_LOCK_EN
        // Lock keeps A through 8 contended cycles; unlocking with a saturated counter hands to B.
        lock = 1'b1;
        step(1, 0, 2'b01, 2'b10, 1, 0, 2'b01, "lk_enter");
        for (int i = 0; i < 8; i++) step(1, 1, 2'b01, 2'b10, 1, 0, 2'b01, "lk_hold");
        lock = 1'b0;
        step(1, 1, 2'b01, 2'b10, 0, 1, 2'b10, "lk_release_b");
        step(0, 0, 2'b01, 2'b10, 0, 0, 2'b00, "lk_idle");
`endif

        repeat (2) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/two_port_rr_arbiter.md
TWO_PORT_RR_ARBITER -- requirements
Module: two_port_rr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 2, data width of each requester and of the shared output.
REQ-002 SHALL have parameter MAX_BURST, default 4, maximum consecutive grant cycles under contention; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_a  input  1  requester A wants the shared channel.
REQ-006 SHALL have port req_b  input  1  requester B wants the shared channel.
REQ-007 SHALL have port a  input  WIDTH  requester A data.
REQ-008 SHALL have port b  input  WIDTH  requester B data.
REQ-009 SHALL have port grant_a  output  1  registered; A owns channel.
REQ-010 SHALL have port grant_b  output  1  registered; B owns channel.
REQ-011 SHALL have port x_var  output  WIDTH  shared channel data.
REQ-012 SHALL have port valid  output  1  grant_a OR grant_b.

Function
REQ-013 SHALL implement FSM states IDLE, GNT_A, GNT_B; grant_a=1 only in GNT_A, grant_b=1 only in GNT_B; never both.
REQ-014 SHALL drive x_var combinationally: a in GNT_A, b in GNT_B, all zeros in IDLE.
REQ-015 SHALL keep a priority pointer (last_was_a); on contention the requester NOT last granted wins; pointer favors A after reset.
REQ-016 SHALL arbitrate at each posedge when in IDLE or when current owner's req is low: both req -> pointer winner; one req -> that one; none -> IDLE.
REQ-017 SHALL grant with one-cycle latency: req sampled at edge N, grant visible after edge N.
REQ-018 SHALL keep a burst counter, cleared on every grant change, incremented each granted cycle, saturating at MAX_BURST-1.
REQ-019 SHALL, while owner req stays high and counter equals MAX_BURST-1 and other req is high, switch to other requester at next edge (exactly MAX_BURST grant cycles under contention).
REQ-020 SHALL, while owner req stays high and other req is low, hold grant indefinitely regardless of counter.
REQ-021 SHALL update pointer on every entry into GNT_A or GNT_B.
REQ-022 SHALL, when owner drops req while other req is high, hand over directly (GNT_A -> GNT_B) without an IDLE cycle.
REQ-023 SHALL treat unreachable state encodings as IDLE on the next edge.

Reset
REQ-024 SHALL on reset high, immediately and independent of clk: state=IDLE, grant_a=0, grant_b=0, valid=0, x_var=0, counter=0, pointer favors A.
REQ-025 SHALL abort any grant in progress when reset asserts mid-burst; first arbitration occurs at the first posedge after reset deasserts.

Configuration
REQ-026 SHALL, with macro ARB_LOCK_EN defined, add port lock  input  1; while lock=1 in GNT_A/GNT_B the burst limit (REQ-019) is suppressed and the owner keeps grant until its req drops.
REQ-027 SHALL, without ARB_LOCK_EN, omit lock port and behave as lock=0.

Verification
REQ-028 SHALL cover: reset=1, req_a=req_b=1 -> grant_a=grant_b=0, x_var=2'b00; release reset -> grant_a=1 after first edge.
REQ-029 SHALL cover: req_a=req_b=1 held, a=2'b01, b=2'b10, MAX_BURST=4 -> x_var alternates 01 x4 cycles, 10 x4 cycles, repeating, valid=1 throughout.
REQ-030 SHALL cover: only req_b=1 for 10 cycles -> grant_b=1 all 10 cycles, no switch; req_b low -> IDLE next edge, valid=0.
REQ-031 SHALL cover: GNT_A, req_a drops at cycle 2 with req_b=1 -> grant_b=1 next edge, no IDLE gap, counter restarts.
REQ-032 SHALL cover: reset asserted asynchronously mid-burst of B -> grant_b=0 before next posedge; after release with both req -> A granted.
REQ-033 SHALL cover (ARB_LOCK_EN): GNT_A, lock=1, both req for 8 cycles -> grant_a held 8 cycles; lock=0 -> switch to B once counter saturated.
